exc_pipe_ctrl: RTL

// Sequencer for the exception/interrupt pipeline registers (D/E/M EXC regs) and the CP0 EPC/Cause/SR

---
 rtl/exc_pipe_ctrl_pkg.sv | 39 +++
 rtl/exc_lock_timer.sv | 32 +++
 rtl/exc_pipe_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/exc_pipe_ctrl_pkg.sv
// Shared constants and types for the exception/interrupt pipeline sequencer.
// Holds the handler vector, the lock window length, the ExcCode encodings,
// the FSM state type and the per-cycle event bundle.
package exc_pipe_ctrl_pkg;

  // Fetch redirect target for every exception and interrupt.
  localparam logic [31:0] HANDLER_PC_DEF  = 32'h0000_4180;

  // Cycles after any redirect during which interrupts are refused.
  localparam int          LOCK_CYCLES_DEF = 3;

  // ExcCode meaning "no exception"; equals the EXC register reset value.
  localparam logic [4:0]  EXC_NONE = 5'b11111;

  // ExcCode encodings written into Cause.
  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_OV   = 5'd12;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Events resolved for the instruction currently in M (mutually exclusive).
  typedef struct packed {
    logic exc;
    logic intr;
    logic eret;
  } ev_t;

  // EPC of a faulting instruction: a delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_lock_timer.sv
// Post-redirect lock window timer: a down-counter loaded on every redirect.
// Ports: clk/reset (sync, active-high); load restarts the window; busy is
//   high while more lock cycles remain after the current one.
module exc_lock_timer #(
  parameter int LOCK_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  // LOCK_CYCLES-1 is the largest value held, so clog2(LOCK_CYCLES) bits suffice.
  localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Zero on the final lock cycle: the FSM leaves LOCK at the following edge.
  assign busy = (cnt != '0);

endmodule

// File: rtl/exc_pipe_ctrl.sv
// Exception/interrupt/ERET sequencer for the D/E/M EXC registers and CP0 update path.
// Ports: hazard stall in, M-stage PC/ExcCode/BD/ERET in, interrupt lines and SR fields
//   in, EPC in; D-stage enable/flush, pipeline flush, CP0 write strobes and fetch redirect out.
module exc_pipe_ctrl
  import exc_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC  = HANDLER_PC_DEF,
  parameter int          LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_req,
  input  logic [31:0] M_PC,
  input  logic [4:0]  M_ExcCode,
  input  logic        M_bd,
  input  logic        M_eret,
  input  logic [5:0]  hw_int,
  input  logic [5:0]  sr_im,
  input  logic        sr_ie,
  input  logic        sr_exl,
  input  logic [31:0] cp0_epc,
  output logic        D_en,
  output logic        D_flush,
  output logic        EXC_flush,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic [4:0]  cause_exc,
  output logic        cause_bd,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  state_t state, state_nxt;
  logic   int_pend;
  logic   int_req;
  logic   lock_busy;
  logic   m_valid;
  logic   redirect;
  ev_t    ev;

  assign m_valid = (M_PC != 32'd0);

  // Interrupt request is only sampled while running; the one-cycle register
  // delay means a request seen on the last LOCK cycle is still dropped.
  assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl & (state == ST_RUN);

  // Priority: exception > interrupt > ERET. Reset suppresses every event.
  // The state term on interrupts covers a request latched on the redirect
  // cycle itself, which would otherwise surface on the first LOCK cycle.
  always_comb begin
    ev      = '0;
    ev.exc  = ~reset & (M_ExcCode != EXC_NONE) & m_valid;
    ev.intr = ~reset & int_pend & (state == ST_RUN) & m_valid & ~ev.exc;
    ev.eret = ~reset & M_eret & ~ev.exc & ~ev.intr;
  end

  assign redirect = ev.exc | ev.intr | ev.eret;

  exc_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk   (clk),
    .reset (reset),
    .load  (redirect),
    .busy  (lock_busy)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      int_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      int_pend <= int_req;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (redirect) state_nxt = ST_LOCK;
      end
      ST_LOCK: begin
        if (redirect)       state_nxt = ST_LOCK;
        else if (!lock_busy) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Output logic (Mealy on the M-stage events)
  always_comb begin
    D_en        = 1'b1;
    D_flush     = 1'b0;
    EXC_flush   = 1'b0;
    epc_we      = 1'b0;
    epc_out     = 32'd0;
    cause_exc   = EXC_INT;
    cause_bd    = 1'b0;
    exl_set     = 1'b0;
    exl_clr     = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;

    if (ev.exc || ev.intr) begin
      EXC_flush   = 1'b1;
      epc_we      = 1'b1;
      exl_set     = 1'b1;
      pc_redirect = 1'b1;
      pc_target   = HANDLER_PC;
      cause_exc   = ev.exc ? M_ExcCode : EXC_INT;
      cause_bd    = M_bd;
      epc_out     = epc_of(M_PC, M_bd);
    end else if (ev.eret) begin
      EXC_flush   = 1'b1;
      exl_clr     = 1'b1;
      pc_redirect = 1'b1;
      pc_target   = cp0_epc;
    end

    // A flush must still clock the D register even when the hazard unit stalls.
    if (!reset) begin
      D_en    = ~stall_req | EXC_flush;
      D_flush = stall_req & ~EXC_flush;
    end
  end

endmodule
